// File: rtl/multi_phase_charge_time_ctrl.sv
// Per-period on-time calculator for N_CH interleaved buck channels sharing one
// restoring divider; results go live at the next period start with phase-shifted gates.
module multi_phase_charge_time_ctrl #(
    parameter int N_CH          = 2,
    parameter int VIN           = 120,
    parameter int L_NH          = 3300,
    parameter int FS_KHZ        = 250,
    parameter int PERIOD_CLK    = 400,
    parameter int MAX_ON_CLK    = 180,
    parameter int I_REF_MAX     = 50,
    parameter int V_GAP_FIXED   = 25,
    parameter int USE_MEAS_VGAP = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [15:0]          timer_period,
    input  logic [16*N_CH-1:0]   sample_current,
    input  logic [15:0]          sample_voltage,
    input  logic [15:0]          i_set,
    output logic [16*N_CH-1:0]   charge_time,
    output logic [N_CH-1:0]      gate,
    output logic [N_CH-1:0]      sat,
    output logic                 calc_busy,
    output logic                 calc_overrun
);
    localparam int     CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int     DIV_STEPS = 40;
    localparam longint VIN_L     = longint'(VIN);
    localparam longint K_E       = 2 * longint'(VIN) * longint'(L_NH) * longint'(FS_KHZ);
    localparam longint K_DEN     = 2 * longint'(VIN) * longint'(1000000 / PERIOD_CLK);

    if (N_CH < 1 || N_CH > 8 || N_CH * 42 >= PERIOD_CLK) begin : g_bad_cfg
        $error("multi_phase_charge_time_ctrl: need N_CH in 1..8 and N_CH*42 < PERIOD_CLK");
    end

    typedef enum logic [1:0] {IDLE, CALC, DIV, STORE} state_t;

    state_t              state;
    logic [CH_W-1:0]     ch;
    logic [5:0]          div_cnt;
    logic [15:0]         id_lat [N_CH];
    logic [15:0]         vg_lat;
    logic [15:0]         iref_lat;
    logic [31:0]         den;
    logic [31:0]         rem;
    logic [39:0]         quo;
    logic                zero_res;
    logic [15:0]         shadow_ct [N_CH];
    logic [N_CH-1:0]     shadow_sat;
    logic [15:0]         active_ct [N_CH];

    logic                period_start;
    logic [15:0]         iset_div;
    logic signed [63:0]  vg_s;
    logic signed [63:0]  e_s;
    logic signed [39:0]  num_calc;
    logic [31:0]         den_calc;
    logic                vg_ge_vin;
    logic [32:0]         rem_shift;
    logic                q_bit;
    logic [15:0]         res_ct;
    logic                res_sat;
    logic [15:0]         ct_next [N_CH];
    logic [N_CH-1:0]     gate_next;

    assign period_start = (timer_period == 16'd0);
    assign iset_div     = i_set / 16'(N_CH);
    assign calc_busy    = (state != IDLE);

    function automatic logic [16:0] phase_of(input int k, input logic [15:0] t);
        logic [16:0] off;
        off = 17'(k * PERIOD_CLK / N_CH);
        return ({1'b0, t} >= off) ? {1'b0, t} - off : {1'b0, t} + 17'(PERIOD_CLK) - off;
    endfunction

    // Operands for the channel selected by ch, formed from the latched samples only.
    always_comb begin
        vg_s      = {{48{vg_lat[15]}}, vg_lat};
        e_s       = $signed({48'd0, iref_lat}) - $signed({48'd0, id_lat[ch]});
        num_calc  = 40'(vg_s * (VIN_L - vg_s) * 64'sd1000000 + K_E * e_s);
        den_calc  = 32'(K_DEN * (VIN_L - vg_s));
        vg_ge_vin = (vg_s >= VIN_L);
        rem_shift = {rem, quo[39]};
        q_bit     = (rem_shift >= {1'b0, den});
    end

    always_comb begin
        res_ct  = '0;
        res_sat = 1'b0;
        if (!zero_res) begin
            if (quo > 40'(MAX_ON_CLK)) begin
                res_ct  = 16'(MAX_ON_CLK);
                res_sat = 1'b1;
            end else begin
                res_ct = quo[15:0];
            end
        end
    end

    // Gate uses the on-time that is live this period, including the one loading right now.
    always_comb begin
        ct_next   = '{default: '0};
        gate_next = '0;
        for (int k = 0; k < N_CH; k++) begin
            ct_next[k]   = period_start ? (enable ? shadow_ct[k] : 16'd0) : active_ct[k];
            gate_next[k] = enable && (phase_of(k, timer_period) < {1'b0, ct_next[k]});
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            ch           <= '0;
            div_cnt      <= '0;
            vg_lat       <= '0;
            iref_lat     <= '0;
            den          <= '0;
            rem          <= '0;
            quo          <= '0;
            zero_res     <= 1'b0;
            shadow_sat   <= '0;
            sat          <= '0;
            gate         <= '0;
            calc_overrun <= 1'b0;
            for (int k = 0; k < N_CH; k++) begin
                id_lat[k]    <= '0;
                shadow_ct[k] <= '0;
                active_ct[k] <= '0;
            end
        end else begin
            calc_overrun <= 1'b0;
            gate         <= gate_next;
            if (period_start) begin
                for (int k = 0; k < N_CH; k++) begin
                    active_ct[k] <= enable ? shadow_ct[k] : 16'd0;
                    id_lat[k]    <= sample_current[16*k+15] ? 16'd0 : sample_current[16*k +: 16];
                end
                sat          <= enable ? shadow_sat : '0;
                vg_lat       <= (USE_MEAS_VGAP != 0) ? sample_voltage : 16'(V_GAP_FIXED);
                iref_lat     <= (iset_div > 16'(I_REF_MAX)) ? 16'(I_REF_MAX) : iset_div;
                calc_overrun <= (state != IDLE);
                ch           <= '0;
                state        <= CALC;
            end else begin
                case (state)
                    CALC: begin
                        den      <= den_calc;
                        rem      <= '0;
                        quo      <= num_calc;
                        div_cnt  <= '0;
                        zero_res <= vg_ge_vin || !(num_calc > 40'sd0);
                        state    <= vg_ge_vin ? STORE : DIV;
                    end
                    DIV: begin
                        rem     <= q_bit ? 32'(rem_shift - {1'b0, den}) : rem_shift[31:0];
                        quo     <= {quo[38:0], q_bit};
                        div_cnt <= div_cnt + 6'd1;
                        if (div_cnt == 6'(DIV_STEPS - 1)) state <= STORE;
                    end
                    STORE: begin
                        shadow_ct[ch]  <= res_ct;
                        shadow_sat[ch] <= res_sat;
                        if (ch == CH_W'(N_CH - 1)) begin
                            state <= IDLE;
                        end else begin
                            ch    <= ch + 1'b1;
                            state <= CALC;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_out
        assign charge_time[16*k +: 16] = active_ct[k];
    end
endmodule

// File: tb/tb_multi_phase_charge_time_ctrl.sv
// Directed bench: fixed-gap and measured-gap instances stepped through hand-computed periods.
module tb_multi_phase_charge_time_ctrl;
    localparam int N_CH   = 2;
    localparam int PERIOD = 400;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] timer_period;
    logic [31:0] sample_current;
    logic [15:0] sample_voltage;
    logic [15:0] i_set;
    logic [31:0] charge_time, charge_time_b;
    logic [1:0]  gate, gate_b, sat, sat_b;
    logic        calc_busy, busy_b, calc_overrun, overrun_b;

    multi_phase_charge_time_ctrl #(.N_CH(N_CH), .USE_MEAS_VGAP(0)) dut (
        .clk(clk), .rst(rst), .enable(enable), .timer_period(timer_period),
        .sample_current(sample_current), .sample_voltage(sample_voltage), .i_set(i_set),
        .charge_time(charge_time), .gate(gate), .sat(sat),
        .calc_busy(calc_busy), .calc_overrun(calc_overrun)
    );

    multi_phase_charge_time_ctrl #(.N_CH(N_CH), .USE_MEAS_VGAP(1)) dut_vg (
        .clk(clk), .rst(rst), .enable(enable), .timer_period(timer_period),
        .sample_current(sample_current), .sample_voltage(sample_voltage), .i_set(i_set),
        .charge_time(charge_time_b), .gate(gate_b), .sat(sat_b),
        .calc_busy(busy_b), .calc_overrun(overrun_b)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          t_last = 0;
    int          hi_cnt [N_CH];
    int          first_hi [N_CH];
    int          last_hi [N_CH];
    int          ovr_cnt, busy_end, busy_end_b;
    logic [31:0] ct_b_cap;
    logic [1:0]  sat_cap;
    logic [31:0] exp_q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    // One clock: DUT samples timer on the edge, outputs are read 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
        t_last       = int'(timer_period);
        timer_period = (timer_period == 16'(PERIOD - 1)) ? 16'd0 : timer_period + 16'd1;
    endtask

    task automatic record();
        for (int k = 0; k < N_CH; k++) begin
            if (gate[k]) begin
                if (hi_cnt[k] == 0) first_hi[k] = t_last;
                last_hi[k] = t_last;
                hi_cnt[k]++;
            end
        end
        if (calc_overrun) ovr_cnt++;
        if (!calc_busy && busy_end < 0) busy_end = t_last;
        if (!busy_b && busy_end_b < 0) busy_end_b = t_last;
    endtask

    task automatic scramble();
        sample_current = $urandom();
        i_set          = 16'($urandom_range(0, 65535));
        sample_voltage = 16'($urandom_range(0, 65535));
    endtask

    // Applies the samples for the coming period start, checks the on-time that goes live,
    // queues the result these samples should produce, then corrupts the sample inputs.
    task automatic start_period(input logic [15:0] id0, input logic [15:0] id1,
                                input logic [15:0] iset, input logic [15:0] volt,
                                input logic [31:0] result);
        logic [31:0] exp_ct;
        sample_current = {id1, id0};
        i_set          = iset;
        sample_voltage = volt;
        for (int k = 0; k < N_CH; k++) begin
            hi_cnt[k]   = 0;
            first_hi[k] = -1;
            last_hi[k]  = -1;
        end
        ovr_cnt    = 0;
        busy_end   = -1;
        busy_end_b = -1;
        step();
        sat_cap  = sat;
        ct_b_cap = charge_time_b;
        record();
        exp_ct = (exp_q.size() > 0) ? exp_q.pop_front() : 32'd0;
        if (!enable) exp_ct = 32'd0;
        check("charge_time_at_start", 64'(charge_time), 64'(exp_ct));
        exp_q.push_back(result);
        scramble();
    endtask

    task automatic finish_period();
        for (int n = 0; n < PERIOD && timer_period != 16'd0; n++) begin
            step();
            record();
        end
    endtask

    task automatic run_to(input int t);
        for (int n = 0; n < PERIOD && t_last != t; n++) begin
            step();
            record();
        end
    endtask

    initial begin
        rst            = 1'b1;
        enable         = 1'b1;
        timer_period   = 16'd0;
        sample_current = {16'd20, 16'd10};
        sample_voltage = 16'd25;
        i_set          = 16'd40;
        repeat (3) @(posedge clk);
        #1;
        check("reset_charge_time", 64'(charge_time), 0);
        check("reset_gate_sat", 64'({gate, sat}), 0);
        check("reset_flags", 64'({calc_busy, calc_overrun}), 0);
        check("reset_vg_outputs", 64'({charge_time_b, gate_b, sat_b, busy_b, overrun_b}), 0);
        rst = 1'b0;

        // id0=10, id1=20, iref 20 -> 76 / 41
        start_period(16'd10, 16'd20, 16'd40, 16'd25, {16'd41, 16'd76});
        check("busy_after_start", 64'(calc_busy), 1);
        check("no_overrun_from_idle", 64'(calc_overrun), 0);
        finish_period();
        check("p0_gates_idle", 64'(hi_cnt[0] + hi_cnt[1]), 0);
        check("p0_busy_end", 64'(busy_end), 84);

        // id0=30 -> 6
        start_period(16'd30, 16'd20, 16'd40, 16'd25, {16'd41, 16'd6});
        check("p1_sat", 64'(sat_cap), 0);
        check("p1_vg_charge_time", 64'(ct_b_cap), 64'({16'd41, 16'd76}));
        finish_period();
        check("p1_gate0_count", 64'(hi_cnt[0]), 76);
        check("p1_gate0_first", 64'(first_hi[0]), 0);
        check("p1_gate0_last", 64'(last_hi[0]), 75);
        check("p1_gate1_count", 64'(hi_cnt[1]), 41);
        check("p1_gate1_first", 64'(first_hi[1]), 200);

        // id0=40 gives NUM<0 -> 0; id1=10 -> 76
        start_period(16'd40, 16'd10, 16'd40, 16'd25, {16'd76, 16'd0});
        finish_period();
        check("p2_gate0_count", 64'(hi_cnt[0]), 6);
        check("p2_gate1_count", 64'(hi_cnt[1]), 41);

        // i_set=200 -> iref capped at 50: id0=50 -> 41, id1=40 -> 76
        start_period(16'd50, 16'd40, 16'd200, 16'd25, {16'd76, 16'd41});
        finish_period();
        check("p3_gate0_never", 64'(hi_cnt[0]), 0);
        check("p3_gate1_count", 64'(hi_cnt[1]), 76);
        check("p3_gate1_first", 64'(first_hi[1]), 200);
        check("p3_gate1_last", 64'(last_hi[1]), 275);

        // i_set=100, id0=0 -> 215 clamped to 180; id1=45 -> 59; measured gap 130 >= VIN
        start_period(16'd0, 16'd45, 16'd100, 16'd130, {16'd59, 16'd180});
        finish_period();
        check("p4_gate0_capped_iref", 64'(hi_cnt[0]), 41);
        check("p4_vg_busy_end", 64'(busy_end_b), 4);

        start_period(16'd10, 16'd20, 16'd40, 16'd25, {16'd41, 16'd76});
        check("p5_sat_clamp", 64'(sat_cap), 64'(2'b01));
        check("p5_vg_zero", 64'(ct_b_cap), 0);
        finish_period();
        check("p5_gate0_count", 64'(hi_cnt[0]), 180);
        check("p5_gate0_last", 64'(last_hi[0]), 179);
        check("p5_gate1_count", 64'(hi_cnt[1]), 59);

        // Overrun during channel 1 division: ch0 already stored 6, ch1 keeps 41
        start_period(16'd30, 16'd10, 16'd40, 16'd25, {16'd76, 16'd6});
        check("p6_sat", 64'(sat_cap), 0);
        run_to(60);
        timer_period   = 16'd0;
        sample_current = {16'd20, 16'd40};
        i_set          = 16'd40;
        sample_voltage = 16'd25;
        void'(exp_q.pop_back());
        exp_q.push_back({16'd41, 16'd0});
        step();
        record();
        check("overrun_pulse", 64'(calc_overrun), 1);
        check("overrun_keeps_shadow", 64'(charge_time), 64'({16'd41, 16'd6}));
        check("overrun_busy", 64'(calc_busy), 1);
        scramble();
        step();
        record();
        check("overrun_one_cycle", 64'(calc_overrun), 0);
        finish_period();
        check("overrun_count", 64'(ovr_cnt), 1);
        check("overrun_recalc_end", 64'(busy_end), 84);

        // enable drops mid-window
        start_period(16'd10, 16'd20, 16'd40, 16'd25, {16'd41, 16'd76});
        run_to(209);
        check("p7_gate_before_disable", 64'(gate), 64'(2'b10));
        enable = 1'b0;
        step();
        record();
        check("p7_gate_after_disable", 64'(gate), 0);
        check("p7_ct_held", 64'(charge_time), 64'({16'd41, 16'd0}));
        finish_period();
        check("p7_gate1_count", 64'(hi_cnt[1]), 10);

        start_period(16'd30, 16'd20, 16'd40, 16'd25, {16'd41, 16'd6});
        check("p8_sat_disabled", 64'(sat_cap), 0);
        enable = 1'b1;
        finish_period();
        check("p8_calc_continues", 64'(busy_end), 84);
        check("p8_gates_low", 64'(hi_cnt[0] + hi_cnt[1]), 0);

        // Async reset in the middle of a division
        start_period(16'd10, 16'd20, 16'd40, 16'd25, {16'd41, 16'd76});
        run_to(3);
        check("p9_gate_before_reset", 64'(gate), 64'(2'b01));
        check("p9_busy_before_reset", 64'(calc_busy), 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_charge_time", 64'(charge_time), 0);
        check("async_reset_gate_sat", 64'({gate, sat}), 0);
        check("async_reset_flags", 64'({calc_busy, calc_overrun}), 0);
        check("async_reset_vg", 64'({charge_time_b, gate_b, busy_b}), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
